// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with access formatting and lock
//
// Purpose: shares one data memory between port 0 (core LSU) and port 1
// (DMA/debug). Each port has a valid/ready request handshake and a registered
// one-cycle response. The granted request drives mem_* combinationally in its
// acceptance cycle. Store data is lane-replicated with a byte mask. Load data
// is extracted and sign/zero-extended. Misaligned accesses and illegal sizes
// are flagged. A per-request lock bit keeps the grant for read-modify-write.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   pN_valid/pN_ready        request handshake (N = 0, 1)
//   pN_we/addr/wdata/size    request: store flag, byte address, LSB-justified
//                            data, size (00 byte, 01 half, 10 word, 11 illegal)
//   pN_unsigned, pN_lock     zero-extend load result; keep grant afterwards
//   pN_rsp_valid/rdata/err   response pulse, formatted load data, error flag
//   mem_addr/wdata/wmask/we  word-aligned memory access of the granted request
//   mem_rdata                asynchronous memory read data
//
// Build option: DMEM_ARB_RR_EN selects round-robin idle arbitration in place
// of fixed port-0 priority with a port-1 starvation override.

module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [1:0]  p0_size,
  input  logic        p0_unsigned,
  input  logic        p0_lock,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [1:0]  p1_size,
  input  logic        p1_unsigned,
  input  logic        p1_lock,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  logic [1:0]  state;
  logic        sel1_idle;
  logic        acc0, acc1, acc;
  logic        r_we, r_uns;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic        err;
  logic        store_ok;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_mask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

`ifdef DMEM_ARB_RR_EN
  // Last granted port; priority goes to the other one.
  logic last_gnt;

  always_comb sel1_idle = p1_valid && (!last_gnt || !p0_valid);
`else
  logic [CNT_W-1:0] starve_cnt;

  // Port 1 also holds the (unused) grant when nobody is requesting.
  always_comb sel1_idle = (p1_valid && (starve_cnt >= CNT_W'(STARVE_LIMIT))) || !p0_valid;
`endif

  // Readiness is forced low while reset is asserted.
  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    if (rst) begin
      case (state)
        ST_LOCK0: p0_ready = 1'b1;
        ST_LOCK1: p1_ready = 1'b1;
        default: begin
          p1_ready = sel1_idle;
          p0_ready = !sel1_idle;
        end
      endcase
    end
  end

  assign acc0 = p0_valid && p0_ready;
  assign acc1 = p1_valid && p1_ready;
  assign acc  = acc0 || acc1;

  // Port 0 inputs feed the memory bus unless port 1 is accepted.
  always_comb begin
    if (acc1) begin
      r_we = p1_we; r_addr = p1_addr; r_wdata = p1_wdata; r_size = p1_size; r_uns = p1_unsigned;
    end else begin
      r_we = p0_we; r_addr = p0_addr; r_wdata = p0_wdata; r_size = p0_size; r_uns = p0_unsigned;
    end
  end

  always_comb begin
    case (r_size)
      2'b00:   err = 1'b0;
      2'b01:   err = r_addr[0];
      2'b10:   err = (r_addr[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    case (r_size)
      2'b00: begin
        fmt_wdata = {4{r_wdata[7:0]}};
        fmt_mask  = 4'b0001 << r_addr[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{r_wdata[15:0]}};
        fmt_mask  = 4'b0011 << {r_addr[1], 1'b0};
      end
      default: begin
        fmt_wdata = r_wdata;
        fmt_mask  = 4'hF;
      end
    endcase
  end

  assign store_ok  = acc && r_we && !err;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wdata = fmt_wdata;
  assign mem_we    = store_ok;
  assign mem_wmask = store_ok ? fmt_mask : 4'h0;

  always_comb begin
    case (r_addr[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   ld_data = r_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = r_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Responses: stores and errors return zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_rsp_valid <= 1'b0;
      p0_rsp_err   <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_valid <= 1'b0;
      p1_rsp_err   <= 1'b0;
      p1_rsp_rdata <= '0;
    end else begin
      p0_rsp_valid <= acc0;
      p0_rsp_err   <= acc0 && err;
      p0_rsp_rdata <= (acc0 && !r_we && !err) ? ld_data : 32'h0;
      p1_rsp_valid <= acc1;
      p1_rsp_err   <= acc1 && err;
      p1_rsp_rdata <= (acc1 && !r_we && !err) ? ld_data : 32'h0;
    end
  end

  // Lock FSM: errored requests still update the lock state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc0 && p0_lock)      state <= ST_LOCK0;
          else if (acc1 && p1_lock) state <= ST_LOCK1;
        end
        ST_LOCK0: if (acc0 && !p0_lock) state <= ST_IDLE;
        ST_LOCK1: if (acc1 && !p1_lock) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last_gnt <= 1'b1;
    else if (acc0) last_gnt <= 1'b0;
    else if (acc1) last_gnt <= 1'b1;
  end
`else
  // Saturating count of cycles port 1 waited while valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 starve_cnt <= '0;
    else if (acc1)                            starve_cnt <= '0;
    else if (p1_valid && (starve_cnt != '1)) starve_cnt <= starve_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data memory between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug).
- Valid/ready request handshake per port; registered one-cycle response per port.
- Generates byte/halfword/word write masks and lane-replicated write data.
- Extracts and sign/zero-extends read data, flags misaligned accesses, and supports a lock for read-modify-write sequences.

Parameters:
STARVE_LIMIT, 4, consecutive cycles port 1 may wait while valid before it takes priority over port 0 (1..15)
CNT_W, 4, width of the starvation counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
p0_valid / p1_valid  in  1  request valid
p0_ready / p1_ready  out  1  request accepted this cycle when valid&ready
p0_we / p1_we  in  1  1=store, 0=load
p0_addr / p1_addr  in  32  byte address
p0_wdata / p1_wdata  in  32  store data, LSB-justified
p0_size / p1_size  in  2  00=byte, 01=half, 10=word, 11=illegal
p0_unsigned / p1_unsigned  in  1  zero-extend load result
p0_lock / p1_lock  in  1  keep grant after this transaction
p0_rsp_valid / p1_rsp_valid  out  1  response pulse, one cycle
p0_rsp_rdata / p1_rsp_rdata  out  32  formatted load data (0 for stores/errors)
p0_rsp_err / p1_rsp_err  out  1  misaligned or illegal size
mem_addr  out  32  {addr[31:2],2'b00} of granted request
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte write mask
mem_we  out  1  write enable
mem_rdata  in  32  asynchronous read data from memory

Behaviour:
- Reset (rst=0): FSM=IDLE, starve counter=0, all rsp_valid/rsp_err=0, all rsp_rdata=0. While in reset, readys and mem_we are 0.
- FSM states:
  - IDLE: arbitrate.
    - Port 1 wins if p1_valid and counter>=STARVE_LIMIT, or if p0_valid=0.
    - Otherwise port 0 wins.
    - Only the winner sees ready=1.
  - LOCK0 / LOCK1: only that port may be granted; the other port's ready=0.
- Transitions:
  - IDLE->LOCKn on an accepted port-n transfer with lock=1.
  - LOCKn->IDLE on an accepted port-n transfer with lock=0.
  - LOCKn stays in LOCKn while port n is idle.
- Starve counter:
  - Increments (saturating) each cycle p1_valid=1 and p1 not accepted.
  - Clears on p1 acceptance.
  - Holds while p1_valid=0.
- Access timing: the granted request drives mem_* combinationally in the acceptance cycle.
  - Store is written at that clock edge.
  - Load samples mem_rdata at that edge.
  - rsp_valid of the granted port is high exactly the next cycle.
  - Throughput is 1 transfer/cycle.
- mem_* outputs with no accepted request: mem_we=0, mem_wmask=0; mem_addr/mem_wdata driven from port 0 inputs.
- Alignment errors: size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11.
  - Request is still accepted; mem_we=0 and mem_wmask=0.
  - Response has rsp_err=1, rdata=0.
  - Lock state still updates per the lock bit.
- Store formatting:
  - byte: wmask=1<<addr[1:0], wdata={4{wdata[7:0]}}.
  - half: wmask=4'b0011<<(2*addr[1]), wdata={2{wdata[15:0]}}.
  - word: wmask=4'hF.
- Load formatting:
  - byte lane addr[1:0]; half lane addr[1].
  - Sign-extended unless unsigned=1; word returned as-is.
  - Loads drive mem_we=0, mem_wmask=0.
- Stores respond with rsp_valid=1, rdata=0, err=0.
- No response backpressure: the requester must take the response pulse.
- Reset mid-lock or with a response pending: return to IDLE; the pending response is dropped (no rsp_valid after reset release until a new acceptance).

Optional Feature:
DMEM_ARB_RR_EN
- Defined: IDLE arbitration is round-robin. A last-grant register (reset value 1) gives priority to the port not most recently granted; the starvation counter and STARVE_LIMIT are unused (counter held 0).
- Undefined: fixed port-0 priority with starvation override as above.
- Lock behaviour is identical in both builds.

Test Plan:
- p0 store word 0xDEADBEEF @0x10, then p0 load byte @0x13 signed -> mem_wmask=4'hF; next load rsp_rdata=0xFFFFFFDE, err=0, rsp_valid exactly 1 cycle after accept.
- p0 store half 0x1234 @0x22 -> mem_wmask=4'b1100, mem_wdata=0x12341234; load half unsigned @0x22 -> 0x00001234.
- p0 load word @0x05 -> accepted, mem_we=0, p0_rsp_err=1, rdata=0; size=11 @0x0 -> err=1.
- p0 and p1 both valid continuously, STARVE_LIMIT=4 (RR off) -> p0 granted 4 cycles, p1 granted on cycle 5, counter clears, p0 resumes.
- p1 load @0x40 with lock=1, then p1 store lock=0 two cycles later while p0 valid throughout -> p0_ready=0 until the p1 unlocking store is accepted, then p0 granted.
- Assert rst=0 during LOCK0 with a load accepted the prior cycle -> FSM IDLE, no p0_rsp_valid, all outputs at reset values.
